hbm_init_ctrl: RTL and testbench
================================

Name: hbm_init_ctrl

Overview:
- Sequences HBM bring-up in the 100 MHz HBM reference clock domain.
- Waits for the HBM clock to lock and settle, then pulses the HBM APB/controller reset and waits for per-stack calibration complete.
- Retries calibration on timeout, then releases the user AXI-side reset and raises init_done.
- Sits between the HBM clock generator and the HBM IP/user AXI logic; also handles lock loss, catastrophic-temperature trip, and software restart.

Parameters:
- NUM_STACKS, 2: number of HBM stacks; width of the apb_complete and cattrip vectors.
- LOCK_SETTLE_CYCLES, 16: cycles that lock must stay high before the reset sequence starts.
- RST_HOLD_CYCLES, 32: cycles hbm_apb_rst is held in HOLD_RST.
- CAL_TIMEOUT_CYCLES, 1000: maximum cycles in WAIT_CAL before a timeout.
- AXI_DELAY_CYCLES, 8: cycles from calibration done to AXI reset release.
- MAX_RETRIES, 2: calibration retries allowed before ERROR.

Ports:
- hbm_clk, input, 1: 100 MHz controller clock.
- hbm_rst, input, 1: reset.
- hbm_clk_locked, input, 1: asynchronous clock lock indication.
- apb_complete, input, NUM_STACKS: asynchronous per-stack calibration complete.
- cattrip, input, NUM_STACKS: asynchronous per-stack catastrophic-temperature trip.
- restart_req, input, 1: single-cycle software re-initialisation request.
- hbm_apb_rst, output, 1: active-high reset to the HBM IP APB/controller.
- hbm_axi_rst, output, 1: active-high reset to user AXI logic.
- init_done, output, 1: high while in READY.
- init_error, output, 1: high while in ERROR.
- error_code, output, 2: 0 = none, 1 = calibration timeout, 2 = cattrip.
- retry_cnt, output, 2: calibration retries used.
- state_o, output, 3: current state encoding.

Behaviour:
- Interface: one clock, hbm_clk; reset hbm_rst is synchronous and active-high.
- Input synchronisation: hbm_clk_locked, apb_complete and cattrip each pass a 2-flop synchronizer. Below, "lock", "cal_ok" and "trip" are the synchronized values.
  - cal_ok = AND of all synchronized apb_complete bits.
  - trip = OR of all synchronized cattrip bits.
  - A change on an input is visible to the FSM 2 edges after it is first sampled.
- State encoding: WAIT_LOCK=0, SETTLE=1, HOLD_RST=2, WAIT_CAL=3, AXI_REL=4, READY=5, ERROR=6. All outputs are Moore decodes of registered state and counters.
  - hbm_apb_rst = 1 in WAIT_LOCK, SETTLE, HOLD_RST, ERROR; 0 otherwise.
  - hbm_axi_rst = 0 only in READY.
  - init_done = (state == READY).
  - init_error = (state == ERROR).
- Reset: synchronous hbm_rst gives state=WAIT_LOCK, cycle counter=0, retry_cnt=0, error_code=0, synchronizers=0. Resulting outputs: hbm_apb_rst=1, hbm_axi_rst=1, init_done=0, init_error=0. Reset mid-sequence behaves identically from any state.
- Cycle counter: 32-bit. Cleared on every state change; otherwise increments each cycle.
- Transitions (priority top-down within each cycle):
  1. trip in any state except ERROR -> ERROR; error_code=2.
  2. restart_req in any state -> WAIT_LOCK; clears retry_cnt and error_code. This is the only exit from ERROR other than hbm_rst.
  3. !lock in SETTLE, HOLD_RST, WAIT_CAL, AXI_REL or READY -> WAIT_LOCK; retry_cnt is kept.
- Per-state rules:
  - WAIT_LOCK: lock -> SETTLE.
  - SETTLE: counter == LOCK_SETTLE_CYCLES-1 -> HOLD_RST.
  - HOLD_RST: counter == RST_HOLD_CYCLES-1 -> WAIT_CAL.
  - WAIT_CAL:
    - cal_ok -> AXI_REL. This wins over a timeout in the same cycle.
    - Else, at counter == CAL_TIMEOUT_CYCLES-1: if retry_cnt < MAX_RETRIES, retry_cnt+1 and go to HOLD_RST; else go to ERROR with error_code=1.
  - AXI_REL:
    - Counter == AXI_DELAY_CYCLES-1 -> READY.
    - If cal_ok drops, go to HOLD_RST without consuming a retry.
  - READY: stays until trip, !lock or restart_req.
- Arithmetic: retry_cnt saturates at MAX_RETRIES and never wraps. The counter never exceeds its terminal value because every terminal compare forces a state change.

Test Plan:
- Nominal bring-up:
  - Stimulus: hbm_rst released; hbm_clk_locked rises; synchronized lock is first seen at edge E.
  - Response: state 1 at E, state 2 at E+16, hbm_apb_rst falls at E+48.
  - Stimulus: apb_complete=2'b11, with synchronized cal_ok first seen at edge C.
  - Response: state 4 at C, hbm_axi_rst falls and init_done=1 at C+8.
- One-stack calibration failure:
  - Stimulus: apb_complete=2'b01 held.
  - Response: retry_cnt=1 at WAIT_CAL entry+1000, with hbm_apb_rst re-asserted for 32 cycles. retry_cnt=2 after the second timeout. The third timeout gives ERROR, init_error=1, error_code=1, hbm_apb_rst=1.
- Lock loss in READY:
  - Stimulus: drop hbm_clk_locked.
  - Response: within 3 edges, state 0, hbm_axi_rst=1, hbm_apb_rst=1, init_done=0. Re-locking repeats the full 16+32 cycle sequence.
- Cattrip priority:
  - Stimulus: cattrip[1]=1 in the same synchronized cycle as cal_ok in WAIT_CAL.
  - Response: ERROR with error_code=2, never AXI_REL.
  - Stimulus: restart_req pulse.
  - Response: state 0, error_code=0, retry_cnt=0.
- Complete/timeout tie:
  - Stimulus: cal_ok first seen at exactly counter=999 in WAIT_CAL.
  - Response: AXI_REL entered, retry_cnt unchanged.
- Synchronous reset mid-WAIT_CAL with retry_cnt=1:
  - Stimulus: one-cycle hbm_rst pulse.
  - Response: next edge shows state 0, retry_cnt=0, all reset-value outputs.

Source files
------------

// File: rtl/hbm_init_ctrl.sv
// -----------------------------------------------------------------------------
// hbm_init_ctrl
//
// Purpose:
//   HBM bring-up sequencer running in the 100 MHz HBM reference clock domain.
//   Waits for the HBM clock to lock and settle, holds the HBM APB/controller
//   reset, waits for every stack to report calibration complete (retrying on
//   timeout), then releases the user AXI-side reset and raises init_done.
//   Lock loss, a catastrophic-temperature trip and a software restart all
//   re-enter the sequence.
//
// Ports:
//   hbm_clk        in   100 MHz controller clock
//   hbm_rst        in   synchronous active-high reset
//   hbm_clk_locked in   asynchronous clock-lock indication
//   apb_complete   in   [NUM_STACKS] asynchronous per-stack calibration done
//   cattrip        in   [NUM_STACKS] asynchronous per-stack temperature trip
//   restart_req    in   single-cycle software re-initialisation request
//   hbm_apb_rst    out  active-high reset to the HBM IP APB/controller
//   hbm_axi_rst    out  active-high reset to user AXI logic
//   init_done      out  high while in READY
//   init_error     out  high while in ERROR
//   error_code     out  [2] 0 none, 1 calibration timeout, 2 cattrip
//   retry_cnt      out  [2] calibration retries used
//   state_o        out  [3] current state encoding
// -----------------------------------------------------------------------------
module hbm_init_ctrl #(
  parameter int NUM_STACKS         = 2,
  parameter int LOCK_SETTLE_CYCLES = 16,
  parameter int RST_HOLD_CYCLES    = 32,
  parameter int CAL_TIMEOUT_CYCLES = 1000,
  parameter int AXI_DELAY_CYCLES   = 8,
  parameter int MAX_RETRIES        = 2
) (
  input  logic                  hbm_clk,
  input  logic                  hbm_rst,
  input  logic                  hbm_clk_locked,
  input  logic [NUM_STACKS-1:0] apb_complete,
  input  logic [NUM_STACKS-1:0] cattrip,
  input  logic                  restart_req,
  output logic                  hbm_apb_rst,
  output logic                  hbm_axi_rst,
  output logic                  init_done,
  output logic                  init_error,
  output logic [1:0]            error_code,
  output logic [1:0]            retry_cnt,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    HOLD_RST  = 3'd2,
    WAIT_CAL  = 3'd3,
    AXI_REL   = 3'd4,
    READY     = 3'd5,
    ERROR     = 3'd6
  } state_t;

  localparam logic [31:0] SETTLE_LAST  = 32'(LOCK_SETTLE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST    = 32'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0] CAL_LAST     = 32'(CAL_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] AXI_LAST     = 32'(AXI_DELAY_CYCLES - 1);
  localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRIES);

  localparam logic [1:0]  ERR_NONE     = 2'd0;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0]  ERR_CATTRIP  = 2'd2;

  // ---------------------------------------------------------------------------
  // Input synchronisers (2 flops each). Every per-stack bit gets its own pair.
  // ---------------------------------------------------------------------------
  logic                  lock_meta_reg;
  logic                  lock_sync_reg;
  logic [NUM_STACKS-1:0] cal_meta_reg;
  logic [NUM_STACKS-1:0] cal_sync_reg;
  logic [NUM_STACKS-1:0] trip_meta_reg;
  logic [NUM_STACKS-1:0] trip_sync_reg;

  always_ff @(posedge hbm_clk) begin
    if (hbm_rst) begin
      lock_meta_reg <= 1'b0;
      lock_sync_reg <= 1'b0;
    end else begin
      lock_meta_reg <= hbm_clk_locked;
      lock_sync_reg <= lock_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STACKS; gi++) begin : g_stack_sync
      always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
          cal_meta_reg[gi]  <= 1'b0;
          cal_sync_reg[gi]  <= 1'b0;
          trip_meta_reg[gi] <= 1'b0;
          trip_sync_reg[gi] <= 1'b0;
        end else begin
          cal_meta_reg[gi]  <= apb_complete[gi];
          cal_sync_reg[gi]  <= cal_meta_reg[gi];
          trip_meta_reg[gi] <= cattrip[gi];
          trip_sync_reg[gi] <= trip_meta_reg[gi];
        end
      end
    end
  endgenerate

  logic lock;
  logic cal_ok;
  logic trip;

  assign lock   = lock_sync_reg;
  assign cal_ok = &cal_sync_reg;   // every stack must be calibrated
  assign trip   = |trip_sync_reg;  // any stack over temperature is fatal

  // ---------------------------------------------------------------------------
  // State, cycle counter, retry and error registers
  // ---------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [1:0]  retry_reg, retry_next;
  logic [1:0]  err_reg, err_next;

  always_ff @(posedge hbm_clk) begin
    if (hbm_rst) begin
      state_reg <= WAIT_LOCK;
      cnt_reg   <= 32'd0;
      retry_reg <= 2'd0;
      err_reg   <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    err_next   = err_reg;

    if (trip && (state_reg != ERROR)) begin
      // Thermal trip beats everything, including a same-cycle cal_ok.
      state_next = ERROR;
      err_next   = ERR_CATTRIP;
    end else if (restart_req) begin
      state_next = WAIT_LOCK;
      retry_next = 2'd0;
      err_next   = ERR_NONE;
    end else if (!lock && (state_reg != WAIT_LOCK) && (state_reg != ERROR)) begin
      // Lock loss restarts the sequence but keeps the retry history.
      state_next = WAIT_LOCK;
    end else begin
      unique case (state_reg)
        WAIT_LOCK: begin
          if (lock) state_next = SETTLE;
        end
        SETTLE: begin
          if (cnt_reg == SETTLE_LAST) state_next = HOLD_RST;
        end
        HOLD_RST: begin
          if (cnt_reg == HOLD_LAST) state_next = WAIT_CAL;
        end
        WAIT_CAL: begin
          // Completion is checked first so a tie with the timeout succeeds.
          if (cal_ok) begin
            state_next = AXI_REL;
          end else if (cnt_reg == CAL_LAST) begin
            if (retry_reg < RETRY_LIMIT) begin
              retry_next = retry_reg + 2'd1;
              state_next = HOLD_RST;
            end else begin
              state_next = ERROR;
              err_next   = ERR_TIMEOUT;
            end
          end
        end
        AXI_REL: begin
          // A stack dropping calibration re-runs the reset pulse for free;
          // it takes precedence over releasing the AXI reset.
          if (!cal_ok) begin
            state_next = HOLD_RST;
          end else if (cnt_reg == AXI_LAST) begin
            state_next = READY;
          end
        end
        READY: begin
          state_next = READY;
        end
        ERROR: begin
          state_next = ERROR;
        end
        default: begin
          state_next = WAIT_LOCK;
        end
      endcase
    end

    // Counter restarts at every state change, so each state measures its own
    // dwell from zero.
    if (state_next != state_reg) begin
      cnt_next = 32'd0;
    end else begin
      cnt_next = cnt_reg + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  assign hbm_apb_rst = (state_reg == WAIT_LOCK) || (state_reg == SETTLE) ||
                       (state_reg == HOLD_RST)  || (state_reg == ERROR);
  assign hbm_axi_rst = (state_reg != READY);
  assign init_done   = (state_reg == READY);
  assign init_error  = (state_reg == ERROR);
  assign error_code  = err_reg;
  assign retry_cnt   = retry_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_hbm_init_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hbm_init_ctrl
//
// Scoreboard bench for hbm_init_ctrl. The stimulus process pushes the expected
// sequence of states (with decoded outputs, retry count, error code and the
// number of cycles spent in the previous state) before provoking it; the
// monitor pops an entry at every state change and checks the outputs on every
// cycle against the most recently popped entry.
// -----------------------------------------------------------------------------
module tb_hbm_init_ctrl;

  localparam int NS = 2;

  logic          hbm_clk;
  logic          hbm_rst;
  logic          hbm_clk_locked;
  logic [NS-1:0] apb_complete;
  logic [NS-1:0] cattrip;
  logic          restart_req;
  logic          hbm_apb_rst;
  logic          hbm_axi_rst;
  logic          init_done;
  logic          init_error;
  logic [1:0]    error_code;
  logic [1:0]    retry_cnt;
  logic [2:0]    state_o;

  hbm_init_ctrl dut (
    .hbm_clk        (hbm_clk),
    .hbm_rst        (hbm_rst),
    .hbm_clk_locked (hbm_clk_locked),
    .apb_complete   (apb_complete),
    .cattrip        (cattrip),
    .restart_req    (restart_req),
    .hbm_apb_rst    (hbm_apb_rst),
    .hbm_axi_rst    (hbm_axi_rst),
    .init_done      (init_done),
    .init_error     (init_error),
    .error_code     (error_code),
    .retry_cnt      (retry_cnt),
    .state_o        (state_o)
  );

  initial hbm_clk = 1'b0;
  always #5 hbm_clk = ~hbm_clk;

  typedef struct {
    logic [10:0] outs;   // {state, apb_rst, axi_rst, done, error, code, retry}
    int          dwell;  // cycles in previous state, 0 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_fail_prints = 0;
  bit   mon_en = 1'b0;

  // Expected outputs for a state, straight from the output table.
  function automatic logic [10:0] exp_outs(input logic [2:0] st,
                                           input logic [1:0] code,
                                           input logic [1:0] retry);
    logic apb, axi, done, err;
    apb  = (st == 3'd0) || (st == 3'd1) || (st == 3'd2) || (st == 3'd6);
    axi  = (st != 3'd5);
    done = (st == 3'd5);
    err  = (st == 3'd6);
    return {st, apb, axi, done, err, code, retry};
  endfunction

  task automatic push(input logic [2:0] st, input logic [1:0] code,
                      input logic [1:0] retry, input int dwell);
    exp_t e;
    e.outs  = exp_outs(st, code, retry);
    e.dwell = dwell;
    exp_q.push_back(e);
  endtask

  task automatic fail_msg(input string name, input int act, input int req);
    n_fail++;
    if (n_fail_prints < 40) begin
      n_fail_prints++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0]  prev;
    logic [10:0] act;
    exp_t        cur;
    bit          have;
    int          cyc, last_cyc;
    prev = 3'd7; have = 1'b0; cyc = 0; last_cyc = 0;
    forever begin
      @(negedge hbm_clk);
      if (mon_en) begin
        cyc++;
        act = {state_o, hbm_apb_rst, hbm_axi_rst, init_done, init_error,
               error_code, retry_cnt};
        if (state_o !== prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            fail_msg("unexpected_transition", int'(state_o), int'(prev));
          end else begin
            cur  = exp_q.pop_front();
            have = 1'b1;
            if (cur.dwell != 0) begin
              n_cmp++;
              if (cyc - last_cyc != cur.dwell)
                fail_msg("dwell", cyc - last_cyc, cur.dwell);
            end
          end
          $display("[%0t] transition -> state %0d retry %0d code %0d dwell %0d",
                   $time, state_o, retry_cnt, error_code, cyc - last_cyc);
          last_cyc = cyc;
          prev     = state_o;
        end
        if (have) begin
          n_cmp++;
          if (act !== cur.outs) fail_msg("outputs", int'(act), int'(cur.outs));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_state(input logic [2:0] st, input logic [1:0] retry,
                            input bit chk_retry, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge hbm_clk);
      if (state_o == st && (!chk_retry || retry_cnt == retry)) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!hit) fail_msg("wait_state_timeout", int'(state_o), int'(st));
  endtask

  task automatic pulse_restart();
    @(negedge hbm_clk);
    restart_req = 1'b1;
    @(negedge hbm_clk);
    restart_req = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    hbm_rst        = 1'b1;
    hbm_clk_locked = 1'b0;
    apb_complete   = '0;
    cattrip        = '0;
    restart_req    = 1'b0;
    repeat (3) @(negedge hbm_clk);

    // Reset state, then nominal bring-up.
    push(3'd0, 2'd0, 2'd0, 0);
    mon_en = 1'b1;
    @(negedge hbm_clk);
    hbm_rst = 1'b0;
    push(3'd1, 2'd0, 2'd0, 0);
    push(3'd2, 2'd0, 2'd0, 16);
    push(3'd3, 2'd0, 2'd0, 32);
    hbm_clk_locked = 1'b1;
    wait_state(3'd3, 2'd0, 1'b0, 200);
    push(3'd4, 2'd0, 2'd0, 13);
    push(3'd5, 2'd0, 2'd0, 8);
    repeat (10) @(negedge hbm_clk);
    apb_complete = 2'b11;
    wait_state(3'd5, 2'd0, 1'b0, 100);

    // Lock loss in READY: state 0 within 3 edges.
    repeat (4) @(negedge hbm_clk);
    push(3'd0, 2'd0, 2'd0, 0);
    hbm_clk_locked = 1'b0;
    apb_complete   = 2'b00;
    wait_state(3'd0, 2'd0, 1'b0, 3);
    repeat (4) @(negedge hbm_clk);

    // Re-lock, then one stack never calibrates: two retries then ERROR.
    push(3'd1, 2'd0, 2'd0, 0);
    push(3'd2, 2'd0, 2'd0, 16);
    push(3'd3, 2'd0, 2'd0, 32);
    push(3'd2, 2'd0, 2'd1, 1000);
    push(3'd3, 2'd0, 2'd1, 32);
    push(3'd2, 2'd0, 2'd2, 1000);
    push(3'd3, 2'd0, 2'd2, 32);
    push(3'd6, 2'd1, 2'd2, 1000);
    hbm_clk_locked = 1'b1;
    apb_complete   = 2'b01;
    wait_state(3'd6, 2'd0, 1'b0, 4000);

    // Restart out of ERROR clears retry and error code.
    apb_complete = 2'b00;
    repeat (4) @(negedge hbm_clk);
    push(3'd0, 2'd0, 2'd0, 0);
    push(3'd1, 2'd0, 2'd0, 1);
    push(3'd2, 2'd0, 2'd0, 16);
    push(3'd3, 2'd0, 2'd0, 32);
    pulse_restart();
    wait_state(3'd3, 2'd0, 1'b0, 200);

    // Cattrip and cal_ok arrive together: ERROR code 2, never AXI_REL.
    push(3'd6, 2'd2, 2'd0, 3);
    apb_complete = 2'b11;
    cattrip      = 2'b10;
    wait_state(3'd6, 2'd0, 1'b0, 10);
    cattrip      = 2'b00;
    apb_complete = 2'b00;
    repeat (4) @(negedge hbm_clk);
    push(3'd0, 2'd0, 2'd0, 0);
    push(3'd1, 2'd0, 2'd0, 1);
    push(3'd2, 2'd0, 2'd0, 16);
    push(3'd3, 2'd0, 2'd0, 32);
    pulse_restart();
    wait_state(3'd3, 2'd0, 1'b0, 200);

    // cal_ok first visible at counter 999: completion wins the tie.
    push(3'd4, 2'd0, 2'd0, 1000);
    push(3'd5, 2'd0, 2'd0, 8);
    repeat (997) @(negedge hbm_clk);
    apb_complete = 2'b11;
    wait_state(3'd5, 2'd0, 1'b0, 100);

    // Back to WAIT_CAL with one retry used, then a one-cycle reset.
    apb_complete = 2'b00;
    push(3'd0, 2'd0, 2'd0, 0);
    push(3'd1, 2'd0, 2'd0, 1);
    push(3'd2, 2'd0, 2'd0, 16);
    push(3'd3, 2'd0, 2'd0, 32);
    push(3'd2, 2'd0, 2'd1, 1000);
    push(3'd3, 2'd0, 2'd1, 32);
    pulse_restart();
    wait_state(3'd3, 2'd1, 1'b1, 2000);
    repeat (5) @(negedge hbm_clk);
    push(3'd0, 2'd0, 2'd0, 0);
    push(3'd1, 2'd0, 2'd0, 3);
    push(3'd2, 2'd0, 2'd0, 16);
    push(3'd3, 2'd0, 2'd0, 32);
    hbm_rst = 1'b1;
    @(negedge hbm_clk);
    hbm_rst = 1'b0;
    n_cmp++;
    if (state_o != 3'd0 || retry_cnt != 2'd0)
      fail_msg("reset_mid_wait_cal", int'({state_o, retry_cnt}), 0);
    wait_state(3'd3, 2'd0, 1'b0, 200);

    // Drain the scoreboard.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge hbm_clk);
    repeat (3) @(negedge hbm_clk);
    n_cmp++;
    if (exp_q.size() != 0) fail_msg("scoreboard_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
